// File: rtl/led_frame_regs.sv
// led_frame_regs: double-buffered LED framebuffer with blink and scroll.
// Ports: clk12MHz, reset (sync, high); bus addr/wdata/wen/ren/rdata;
//   leds1..leds4 are registered column patterns, bit = 1 lights the LED.
module led_frame_regs #(
  parameter int BLINK_DIV  = 22,
  parameter int SCROLL_DIV = 21
) (
  input  logic        clk12MHz,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic [7:0]  leds1,
  output logic [7:0]  leds2,
  output logic [7:0]  leds3,
  output logic [7:0]  leds4
);

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]           r_front;
  logic [31:0]           r_back;
  logic [31:0]           r_mask;
  logic [3:1]            r_ctrl;
  logic [11:0]           r_frame_ctr;
  logic [7:0]            r_fcnt;
  logic [BLINK_DIV-1:0]  r_blink_ctr;
  logic                  r_phase;
  logic [SCROLL_DIV-1:0] r_scroll_ctr;
  logic [31:0]           r_leds;
  logic [31:0]           r_rdata;

  logic        w_boundary;
  logic        w_ctrl_wr;
  logic        w_swap_wr;
  logic        w_swap_go;
  logic        w_tick;
  logic        w_pending;
  logic [31:0] w_rot;
  logic [31:0] w_leds;
  logic [31:0] w_rd;

  assign w_boundary = &r_frame_ctr;
  assign w_ctrl_wr  = wen && (addr == 2'd1);
  assign w_swap_wr  = w_ctrl_wr && wdata[0];
  assign w_pending  = (r_state == S_PEND);
  assign w_tick     = r_ctrl[2] && (&r_scroll_ctr);

  // Left moves each column one slot toward col1; right the reverse.
  assign w_rot = r_ctrl[3] ? {r_front[23:0], r_front[31:24]}
                           : {r_front[7:0], r_front[31:8]};

  assign w_leds = r_front &
                  ~(r_mask & {32{r_ctrl[1] & r_phase}});

  // A SWAP written on the boundary cycle re-arms the FSM for next frame.
  always_comb begin
    w_state_nxt = r_state;
    w_swap_go   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_swap_wr) w_state_nxt = S_PEND;
      end
      S_PEND: begin
        if (w_boundary) begin
          w_swap_go = 1'b1;
          if (!w_swap_wr) w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_rd = 32'd0;
    unique case (addr)
      2'd0: w_rd = r_back;
      2'd1: w_rd = {28'd0, r_ctrl, w_pending};
      2'd2: w_rd = r_mask;
      2'd3: w_rd = {16'd0, r_fcnt, 6'd0, r_phase, w_pending};
    endcase
  end

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_front      <= 32'd0;
      r_back       <= 32'd0;
      r_mask       <= 32'd0;
      r_ctrl       <= 3'd0;
      r_frame_ctr  <= 12'd0;
      r_fcnt       <= 8'd0;
      r_blink_ctr  <= '0;
      r_phase      <= 1'b0;
      r_scroll_ctr <= '0;
      r_leds       <= 32'd0;
      r_rdata      <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_ctr <= r_frame_ctr + 12'd1;
      r_blink_ctr <= r_blink_ctr + BLINK_DIV'(1);
      r_leds      <= w_leds;

      if (w_boundary) r_fcnt <= r_fcnt + 8'd1;
      if (&r_blink_ctr) r_phase <= ~r_phase;

      // Held at zero while disabled so re-enable starts a fresh period.
      if (r_ctrl[2]) r_scroll_ctr <= r_scroll_ctr + SCROLL_DIV'(1);
      else           r_scroll_ctr <= '0;

      // Swap beats a coincident scroll step.
      if (w_swap_go)   r_front <= r_back;
      else if (w_tick) r_front <= w_rot;

      if (wen && addr == 2'd0) r_back <= wdata;
      if (wen && addr == 2'd2) r_mask <= wdata;
      if (w_ctrl_wr)           r_ctrl <= wdata[3:1];

      if (ren) r_rdata <= w_rd;
    end
  end

  assign rdata = r_rdata;
  assign leds1 = r_leds[7:0];
  assign leds2 = r_leds[15:8];
  assign leds3 = r_leds[23:16];
  assign leds4 = r_leds[31:24];

endmodule

// File: tb/tb_led_frame_regs.sv
// tb_led_frame_regs: directed checks of swap, scroll, blink and reset.
// Drives led_frame_regs with short blink/scroll periods.
module tb_led_frame_regs;

  logic        clk12MHz = 1'b0;
  logic        reset    = 1'b1;
  logic [1:0]  addr     = 2'd0;
  logic [31:0] wdata    = 32'd0;
  logic        wen      = 1'b0;
  logic        ren      = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  leds1, leds2, leds3, leds4;

  int checks = 0;
  int errors = 0;

  logic [11:0] tb_fc;
  logic [2:0]  tb_bc;
  logic        tb_ph;
  logic        tb_ph_d;
  logic [31:0] rv;

  led_frame_regs #(
    .BLINK_DIV (3),
    .SCROLL_DIV(4)
  ) dut (
    .clk12MHz(clk12MHz),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .wen     (wen),
    .ren     (ren),
    .rdata   (rdata),
    .leds1   (leds1),
    .leds2   (leds2),
    .leds3   (leds3),
    .leds4   (leds4)
  );

  always #5 clk12MHz = ~clk12MHz;

  // Reference frame counter and blink phase (tb_ph_d is one cycle late).
  always @(posedge clk12MHz) begin
    if (reset) begin
      tb_fc   <= 12'd0;
      tb_bc   <= 3'd0;
      tb_ph   <= 1'b0;
      tb_ph_d <= 1'b0;
    end else begin
      tb_fc   <= tb_fc + 12'd1;
      tb_bc   <= tb_bc + 3'd1;
      if (tb_bc == 3'd7) tb_ph <= ~tb_ph;
      tb_ph_d <= tb_ph;
    end
  end

  function automatic logic [31:0] leds_all();
    return {leds4, leds3, leds2, leds1};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    @(negedge clk12MHz);
    wen   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    ren  = 1'b1;
    @(negedge clk12MHz);
    ren  = 1'b0;
    d    = rdata;
  endtask

  task automatic wait_fc(input logic [11:0] v);
    int n;
    n = 0;
    while (tb_fc != v && n < 5000) begin
      @(negedge clk12MHz);
      n++;
    end
    if (tb_fc != v) chk("wait_fc_timeout", {20'd0, tb_fc}, {20'd0, v});
  endtask

  task automatic wait_swap();
    wait_fc(12'd4095);
    @(negedge clk12MHz);
    @(negedge clk12MHz);
  endtask

  initial begin
    repeat (3) @(negedge clk12MHz);
    reset = 1'b0;
    chk("reset_leds", leds_all(), 32'h0);
    chk("reset_rdata", rdata, 32'h0);

    // Basic swap at the frame boundary.
    wr(2'd0, 32'h8001_FF0F);
    wr(2'd1, 32'h1);
    rd(2'd3, rv);
    chk("pend_before", rv & 32'hFF01, 32'h0001);
    wait_fc(12'd4094);
    chk("leds_pre_4094", leds_all(), 32'h0);
    @(negedge clk12MHz);
    chk("leds_pre_4095", leds_all(), 32'h0);
    @(negedge clk12MHz);
    chk("leds_lag", leds_all(), 32'h0);
    @(negedge clk12MHz);
    chk("leds1", {24'd0, leds1}, 32'h0F);
    chk("leds2", {24'd0, leds2}, 32'hFF);
    chk("leds3", {24'd0, leds3}, 32'h01);
    chk("leds4", {24'd0, leds4}, 32'h80);
    rd(2'd3, rv);
    chk("pend_after", rv & 32'hFF01, 32'h0100);

    // Newest BACK wins.
    wr(2'd1, 32'h1);
    wr(2'd0, 32'h1111_1111);
    wr(2'd0, 32'h2222_2222);
    rd(2'd3, rv);
    chk("pend_fc1", rv & 32'hFF01, 32'h0101);
    wait_swap();
    chk("newest_back", leds_all(), 32'h2222_2222);

    // Scroll left.
    wr(2'd0, 32'h0403_0201);
    wr(2'd1, 32'h1);
    wait_swap();
    chk("front_load", leds_all(), 32'h0403_0201);
    wr(2'd1, 32'h4);
    repeat (16) @(negedge clk12MHz);
    chk("scroll_l_pre", leds_all(), 32'h0403_0201);
    @(negedge clk12MHz);
    chk("scroll_left", leds_all(), 32'h0104_0302);
    wr(2'd1, 32'h0);

    // Scroll right.
    wr(2'd0, 32'h0403_0201);
    wr(2'd1, 32'h1);
    wait_swap();
    chk("front_load2", leds_all(), 32'h0403_0201);
    wr(2'd1, 32'hC);
    repeat (16) @(negedge clk12MHz);
    @(negedge clk12MHz);
    chk("scroll_right", leds_all(), 32'h0302_0104);
    wr(2'd1, 32'h0);

    // Blink on column 1 upper nibble.
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'h1);
    wait_swap();
    chk("front_ones", leds_all(), 32'hFFFF_FFFF);
    wr(2'd2, 32'h0000_00F0);
    wr(2'd1, 32'hFFFF_FFF2);
    @(negedge clk12MHz);
    for (int i = 0; i < 20; i++) begin
      chk("blink", leds_all(),
          {24'hFF_FFFF, tb_ph_d ? 8'h0F : 8'hFF});
      @(negedge clk12MHz);
    end
    rd(2'd3, rv);
    chk("status_phase", {31'd0, rv[1]}, {31'd0, tb_ph_d});
    rd(2'd1, rv);
    chk("ctrl_read", rv, 32'h0000_0002);

    // Read and write together: read returns old contents.
    addr  = 2'd2;
    wdata = 32'h1234_5678;
    wen   = 1'b1;
    ren   = 1'b1;
    @(negedge clk12MHz);
    wen   = 1'b0;
    ren   = 1'b0;
    chk("rw_old", rdata, 32'h0000_00F0);
    rd(2'd2, rv);
    chk("rw_new", rv, 32'h1234_5678);
    wr(2'd1, 32'h0);

    // Scroll tick coincides with swap boundary: swap wins.
    wr(2'd0, 32'h4433_2211);
    wait_fc(12'd4079);
    wr(2'd1, 32'h5);
    wait_fc(12'd4095);
    @(negedge clk12MHz);
    @(negedge clk12MHz);
    chk("swap_beats_scroll", leds_all(), 32'h4433_2211);
    wr(2'd1, 32'h0);

    // SWAP written on the boundary cycle stays pending.
    wr(2'd0, 32'h5555_5555);
    wr(2'd1, 32'h1);
    wait_fc(12'd4095);
    wr(2'd1, 32'h1);
    @(negedge clk12MHz);
    chk("swap_on_bnd", leds_all(), 32'h5555_5555);
    rd(2'd3, rv);
    chk("still_pend", rv & 32'h1, 32'h1);
    wr(2'd0, 32'h6666_6666);
    wait_swap();
    chk("second_swap", leds_all(), 32'h6666_6666);
    rd(2'd3, rv);
    chk("pend_clear", rv & 32'h1, 32'h0);

    // Reset while pending abandons the swap.
    wr(2'd0, 32'hAAAA_AAAA);
    wr(2'd1, 32'h1);
    reset = 1'b1;
    @(negedge clk12MHz);
    reset = 1'b0;
    chk("rst_leds", leds_all(), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rd(2'd3, rv);
    chk("rst_status", rv, 32'h0);
    rd(2'd0, rv);
    chk("rst_back", rv, 32'h0);
    wait_swap();
    chk("no_swap", leds_all(), 32'h0);
    rd(2'd3, rv);
    chk("rst_fcnt", rv & 32'hFF01, 32'h0100);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
